// File: rtl/signed_divmod_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : signed_divmod_seq_if
// Description : Operand/result handshake bundle for signed_divmod_seq.
// Revision    : 1.0 - initial release
// ============================================================================
interface signed_divmod_seq_if #(
  parameter int W     = 8,
  parameter int OUT_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     dividend;
  logic [W-1:0]     divisor;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     quotient;
  logic [W-1:0]     remainder;
  logic [OUT_W-1:0] rem_ext;
  logic             div_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, rem_ext, div_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, rem_ext, div_zero
  );
endinterface
`default_nettype wire

// File: rtl/signed_divmod_seq.sv
`default_nettype none
// ============================================================================
// Module      : signed_divmod_seq
// Description : Multi-cycle restoring signed divider, truncating quotient and
//               dividend-signed remainder, with sign-extended remainder bus.
// Revision    : 1.0 - initial release
// ============================================================================
module signed_divmod_seq #(
  parameter int W     = 8,
  parameter int OUT_W = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  signed_divmod_seq_if.slave   bus
);
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_count;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div_zero;
  logic [W-1:0]     r_dividend;
  logic [W-1:0]     r_div_mag;
  logic [W-1:0]     r_quo;
  logic [W-1:0]     r_rem;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [W-1:0]     r_quotient;
  logic [W-1:0]     r_remainder;
  logic [OUT_W-1:0] r_rem_ext;
  logic             r_dz_out;

  logic [W:0]       w_shift;
  logic [W-1:0]     w_diff;
  logic             w_fits;
  logic [W-1:0]     w_rem_next;
  logic [W-1:0]     w_quo_next;
  logic [W-1:0]     w_q_signed;
  logic [W-1:0]     w_r_signed;
  logic [OUT_W-1:0] w_r_ext;
  logic [W-1:0]     w_dd_mag;
  logic [W-1:0]     w_dv_mag;

  // One restoring step; when the trial subtract fits, the true difference is
  // below the divisor, so the W-bit modular result is exact.
  always_comb begin
    w_dd_mag   = bus.dividend[W-1] ? -bus.dividend : bus.dividend;
    w_dv_mag   = bus.divisor[W-1]  ? -bus.divisor  : bus.divisor;
    w_shift    = {r_rem, r_quo[W-1]};
    w_fits     = (w_shift >= {1'b0, r_div_mag});
    w_diff     = w_shift[W-1:0] - r_div_mag;
    w_rem_next = w_fits ? w_diff : w_shift[W-1:0];
    w_quo_next = {r_quo[W-2:0], w_fits};
    w_q_signed = r_div_zero ? {W{1'b1}}  : (r_neg_q ? -w_quo_next : w_quo_next);
    w_r_signed = r_div_zero ? r_dividend : (r_neg_r ? -w_rem_next : w_rem_next);
  end

  generate
    if (OUT_W > W) begin : g_ext
      assign w_r_ext = {{(OUT_W-W){w_r_signed[W-1]}}, w_r_signed};
    end else begin : g_noext
      assign w_r_ext = w_r_signed;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_div_zero  <= 1'b0;
      r_dividend  <= '0;
      r_div_mag   <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_rem_ext   <= '0;
      r_dz_out    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_neg_q    <= bus.dividend[W-1] ^ bus.divisor[W-1];
            r_neg_r    <= bus.dividend[W-1];
            r_div_zero <= (bus.divisor == '0);
            r_dividend <= bus.dividend;
            r_quo      <= w_dd_mag;
            r_div_mag  <= w_dv_mag;
            r_rem      <= '0;
            r_count    <= CW'(W);
            r_in_ready <= 1'b0;
            r_state    <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_rem   <= w_rem_next;
          r_quo   <= w_quo_next;
          r_count <= r_count - 1'b1;
          if (r_count == CW'(1)) begin
            r_quotient  <= w_q_signed;
            r_remainder <= w_r_signed;
            r_rem_ext   <= w_r_ext;
            r_dz_out    <= r_div_zero;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;
  assign bus.rem_ext   = r_rem_ext;
  assign bus.div_zero  = r_dz_out;
endmodule
`default_nettype wire
